// File: rtl/tdc_hit_generator.sv
`default_nettype none
// ============================================================================
// Module      : tdc_hit_generator
// Description : Programmable hit-pulse transmitter for TDC self-test and
//               calibration. Emits glitch-free registered pulses of width Wh
//               separated by Lo low cycles, as a finite burst or continuously
//               until stopped. Optional feature macro: HITGEN_RANDOM_EN adds
//               an 8-bit LFSR that stretches each low phase by lfsr[3:0].
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_hit_generator #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   width,
    input  logic [CNT_W-1:0]   period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               hit_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] hit_count
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_HIGH   = 2'd1;
    localparam logic [1:0] c_LOW    = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] c_BURST_ONE = BURST_W'(1);
    localparam logic [BURST_W-1:0] c_BURST_MAX = '1;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_wh;
    logic [CNT_W-1:0]   r_period;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] r_count;
    logic               r_stop;
    logic               r_hit;
    logic               r_busy;
    logic               r_done;

    logic [CNT_W-1:0]   w_wh_new;
    logic [CNT_W-1:0]   w_lo;
    logic [CNT_W-1:0]   w_lo_len;
    logic [BURST_W-1:0] w_count_inc;
    logic               w_cnt_exp;
    logic               w_stop_pend;
    logic               w_burst_done;
    logic               w_end_seq;

    // A zero width still produces a one-cycle pulse
    assign w_wh_new     = (width == '0) ? c_CNT_ONE : width;
    // At least one low cycle separates hits even when period <= Wh
    assign w_lo         = (r_period > r_wh) ? (r_period - r_wh) : c_CNT_ONE;
    assign w_cnt_exp    = (r_cnt <= c_CNT_ONE);
    // A stop arriving in the very cycle the low phase expires still counts
    assign w_stop_pend  = r_stop | stop;
    assign w_burst_done = (r_burst != '0) && (r_count == r_burst);
    assign w_end_seq    = w_stop_pend | w_burst_done;
    assign w_count_inc  = (r_count == c_BURST_MAX) ? r_count : (r_count + c_BURST_ONE);

`ifdef HITGEN_RANDOM_EN
    logic [7:0] r_lfsr;
    logic       w_enter_high;

    assign w_enter_high = ((r_state == c_IDLE) && start) ||
                          ((r_state == c_LOW) && w_cnt_exp && !w_end_seq);
    assign w_lo_len     = w_lo + CNT_W'(r_lfsr[3:0]);

    // Fibonacci LFSR (taps 8,6,5,4), stepped once per high-phase entry, not reseeded by start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 8'hA5;
        end else if (w_enter_high) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end
`else
    assign w_lo_len = w_lo;
`endif

    // Latch the programmed shape on an accepted start only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wh     <= c_CNT_ONE;
            r_period <= '0;
            r_burst  <= '0;
        end else if ((r_state == c_IDLE) && start) begin
            r_wh     <= w_wh_new;
            r_period <= period;
            r_burst  <= burst_len;
        end
    end

    // Sticky abort flag: armed while busy (or alongside an accepted start), cleared in FINISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop <= 1'b0;
        end else if (r_state == c_FINISH) begin
            r_stop <= 1'b0;
        end else if (stop && ((r_state != c_IDLE) || start)) begin
            r_stop <= 1'b1;
        end
    end

    // Sequencer with registered outputs; stop is only honoured at the end of a low phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_hit   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_HIGH;
                        r_cnt   <= w_wh_new;
                        r_hit   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_count <= c_BURST_ONE;
                    end
                end
                c_HIGH: begin
                    if (w_cnt_exp) begin
                        r_state <= c_LOW;
                        r_cnt   <= w_lo_len;
                        r_hit   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_LOW: begin
                    if (w_cnt_exp) begin
                        if (w_end_seq) begin
                            r_state <= c_FINISH;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_HIGH;
                            r_cnt   <= r_wh;
                            r_hit   <= 1'b1;
                            r_count <= w_count_inc;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_FINISH: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign hit_out   = r_hit;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hit_count = r_count;

endmodule
`default_nettype wire

// File: doc/tdc_hit_generator.md
# tdc_hit_generator

Programmable hit-pulse transmitter for TDC self-test and calibration. It drives the hit input of the TDC stop-conditioning stage with clean, glitch-free pulses of programmed width and period, either as a finite burst or continuously. The start handshake and status outputs connect to the control/readout logic. The pulse counter gives the expected hit total, to be compared against the number of TDC valid events.

## Interface
Parameters:
- CNT_W, 16, width of the pulse-width and period counters
- BURST_W, 8, width of the burst-length field and hit counter

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a sequence; ignored while busy
- stop  input  1  abort request; level or pulse
- width  input  CNT_W  high time in clk cycles; 0 treated as 1
- period  input  CNT_W  hit-to-hit spacing in clk cycles
- burst_len  input  BURST_W  number of hits; 0 = continuous until stop
- hit_out  output  1  registered hit pulse to the TDC input
- busy  output  1  high from the cycle after start until the sequence ends
- done  output  1  one-cycle pulse at the end of a sequence (normal or aborted)
- hit_count  output  BURST_W  hits emitted since the last accepted start; saturates at all-ones

## Operation
- Parameter latching: width, period and burst_len are latched on the accepted start. Later changes have no effect until the next start.
- Derived values:
  - Wh = max(width, 1)
  - Lo = period − Wh if period > Wh, else 1 (minimum one low cycle between hits)
  - All arithmetic is in CNT_W bits and unsigned.
- FSM states:
  - IDLE: outputs low, except done during its pulse cycle.
    - start → HIGH: load the high counter with Wh and clear hit_count.
  - HIGH: hit_out = 1.
    - When the high counter expires → LOW: load the low counter with Lo.
    - hit_count increments on entry to HIGH.
  - LOW: hit_out = 0.
    - When the low counter expires:
      - If stop is pending, or the hits emitted equal a nonzero burst_len → FINISH.
      - Otherwise → HIGH.
  - FINISH: one cycle; done = 1, busy = 0 → IDLE.
- Stop handling:
  - stop is captured into a sticky flag while busy.
  - stop never truncates a high phase; no runt pulses reach the TDC.
  - A stop during LOW ends at the normal LOW expiry.
  - The flag clears in FINISH.
- Start handling:
  - A start while busy (HIGH/LOW/FINISH) is dropped, with no queueing.
  - start and stop in the same IDLE cycle: the start is accepted and the stop is latched. Exactly one hit is emitted, then FINISH.
- hit_count is held after the sequence ends until the next accepted start.

## Timing
- Reset values: hit_out = 0, busy = 0, done = 0, hit_count = 0, FSM = IDLE, stop flag = 0. Reset is effective immediately and asynchronously, including mid-pulse; hit_out drops without waiting for a clock.
- start sampled high at edge N:
  - busy = 1 and hit_out = 1 after edge N.
  - hit_out stays high for exactly Wh cycles.
- Hit-to-hit rising-edge spacing is Wh + Lo cycles, i.e. period when period > Wh.
- Finite burst B: done pulses in the cycle after the last LOW phase. Total sequence length is B·(Wh+Lo) + 1 cycles from the first hit_out rise to the done cycle.
- A new start is accepted no earlier than the cycle after FINISH (IDLE). Back-to-back sequences are therefore separated by at least one idle cycle.
- hit_out is driven directly from a flop; no combinational path reaches the TDC input.

## Configuration
- HITGEN_RANDOM_EN defined:
  - Adds an 8-bit Fibonacci LFSR: taps 8,6,5,4; seed 8'hA5 on reset; advances once per HIGH entry.
  - Each LOW phase length is Lo + lfsr[3:0], which spreads hit phases for code-density calibration.
  - The LFSR is not reseeded by start.
- HITGEN_RANDOM_EN undefined:
  - No LFSR logic is present.
  - LOW length is exactly Lo.

## Test plan
- Basic burst: width=3, period=10, burst_len=4, start at cycle 0 → four 3-cycle pulses with rising edges at cycles 1, 11, 21, 31; done at cycle 41; hit_count=4; busy low at cycle 41.
- Degenerate values: width=0, period=0, burst_len=2 → two 1-cycle pulses separated by one low cycle; done follows; hit_count=2.
- Continuous with stop: burst_len=0, width=5, period=20; stop asserted in the 3rd cycle of the 7th pulse → the 7th pulse is full width (5 cycles); no 8th pulse; done after the 7th LOW phase; hit_count=7.
- Start ignored while busy: start asserted during HIGH and during FINISH → no restart; hit_count is not cleared; the sequence completes as programmed.
- Reset mid-pulse: rst_n low during HIGH → hit_out, busy, done and hit_count read 0 before the next clk edge. After release, the block is idle and the next start works normally.
- With HITGEN_RANDOM_EN: width=2, period=8, burst_len=16 → every low gap lies in 6..21 cycles and matches a reference LFSR model from seed 8'hA5. Without the macro, every gap is exactly 6 cycles.
